// File: rtl/pwm_receiver_decoder.sv
// RC receiver PWM decoder: measures the width of each pulse and maps 1000..2000 us to 0..250, with a failsafe on timeout.
// Latency: value_valid strobes 2 cycles after the falling edge is detected. There is no backpressure; each strobe lasts one cycle.
`ifndef REC_VAL_BIT_WIDTH
`define REC_VAL_BIT_WIDTH 8
`endif

module pwm_receiver_decoder #(
   parameter int MIN_VALID_US  = 900,
   parameter int MAX_VALID_US  = 2100,
   parameter int TIMEOUT_US    = 25000,
   parameter int RECOVER_COUNT = 3
) (
   input  logic                          us_clk,
   input  logic                          resetn,
   input  logic                          pwm_in,
   output logic [`REC_VAL_BIT_WIDTH-1:0] value_out,
   output logic                          value_valid,
   output logic                          signal_lost
);

   localparam int TW = $clog2(TIMEOUT_US + 1);
   localparam int RW = $clog2(RECOVER_COUNT + 1);

   localparam logic [4:0] S_WAIT_LOW = 5'b00001;
   localparam logic [4:0] S_IDLE     = 5'b00010;
   localparam logic [4:0] S_MEASURE  = 5'b00100;
   localparam logic [4:0] S_CONVERT  = 5'b01000;
   localparam logic [4:0] S_PUBLISH  = 5'b10000;

   localparam logic [11:0]   MIN_W    = 12'(MIN_VALID_US);
   localparam logic [11:0]   MAX_W    = 12'(MAX_VALID_US);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_US);
   localparam logic [TW-1:0] TMO_PRE  = TW'(TIMEOUT_US - 1);
   localparam logic [RW-1:0] REC_LAST = RW'(RECOVER_COUNT - 1);

   logic                          r_sync1;
   logic                          r_sync2;
   logic                          r_sync_q;
   logic [1:0]                    r_fill;
   logic [4:0]                    r_state;
   logic [11:0]                   r_width;
   logic [TW-1:0]                 r_tmo;
   logic [RW-1:0]                 r_rec;
   logic [`REC_VAL_BIT_WIDTH-1:0] r_value;
   logic                          r_valid;
   logic                          r_lost;

   logic                          w_rise;
   logic                          w_fall;
   logic                          w_accept;
   logic                          w_publish;
   logic                          w_tmo_fire;
   logic [`REC_VAL_BIT_WIDTH-1:0] w_conv;

   assign w_rise     = r_sync2 & ~r_sync_q;
   assign w_fall     = ~r_sync2 & r_sync_q;
   assign w_accept   = (r_width >= MIN_W) && (r_width <= MAX_W);
   assign w_publish  = (r_state == S_CONVERT) && w_accept;
   // An accepted publish on the expiry cycle wins and clears the counter instead.
   assign w_tmo_fire = (r_tmo == TMO_PRE) && !w_publish && !r_lost;

   always_comb begin
      w_conv = '0;
      if (r_width >= 12'd2000) begin
         w_conv = `REC_VAL_BIT_WIDTH'(250);
      end else if (r_width > 12'd1000) begin
         w_conv = `REC_VAL_BIT_WIDTH'((r_width - 12'd1000) >> 2);
      end
   end

   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_sync_q <= 1'b0;
         r_fill   <= 2'b00;
         r_state  <= S_WAIT_LOW;
         r_width  <= '0;
         r_tmo    <= '0;
         r_rec    <= '0;
         r_value  <= '0;
         r_valid  <= 1'b0;
         r_lost   <= 1'b1;
      end else begin
         r_sync1  <= pwm_in;
         r_sync2  <= r_sync1;
         r_sync_q <= r_sync2;
         // r_fill marks when the synchronizer holds real samples rather than reset zeros.
         r_fill   <= {r_fill[0], 1'b1};
         r_valid  <= 1'b0;

         if (w_publish) begin
            r_tmo <= '0;
         end else if (r_tmo != TMO_MAX) begin
            r_tmo <= r_tmo + TW'(1);
         end

         if (w_tmo_fire) begin
            r_lost  <= 1'b1;
            r_value <= '0;
            r_valid <= 1'b1;
         end

         case (r_state)
            S_WAIT_LOW: begin
               if (r_fill[1] && !r_sync2) begin
                  r_state <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (w_rise) begin
                  r_state <= S_MEASURE;
                  r_width <= 12'd1;
               end
            end
            S_MEASURE: begin
               if (w_fall) begin
                  r_state <= S_CONVERT;
               end else if (r_sync2 && (r_width != 12'hFFF)) begin
                  r_width <= r_width + 12'd1;
               end
            end
            S_CONVERT: begin
               if (w_accept) begin
                  r_state <= S_PUBLISH;
                  if (!r_lost) begin
                     r_value <= w_conv;
                     r_valid <= 1'b1;
                  end else if (r_rec == REC_LAST) begin
                     r_value <= w_conv;
                     r_valid <= 1'b1;
                     r_lost  <= 1'b0;
                     r_rec   <= '0;
                  end else begin
                     r_rec <= r_rec + RW'(1);
                  end
               end else begin
                  r_state <= S_IDLE;
                  r_rec   <= '0;
               end
            end
            S_PUBLISH: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_WAIT_LOW;
            end
         endcase
      end
   end

   assign value_out   = r_value;
   assign value_valid = r_valid;
   assign signal_lost = r_lost;

endmodule

// File: tb/tb_pwm_receiver_decoder.sv
// Directed bench for pwm_receiver_decoder: pulse widths, boundaries, failsafe entry/recovery and mid-pulse reset.
`timescale 1ns/1ps

module tb_pwm_receiver_decoder;

   localparam int TMO = 5000;

   logic       us_clk;
   logic       resetn;
   logic       pwm_in;
   logic [7:0] value_out;
   logic       value_valid;
   logic       signal_lost;

   int n_vec = 0;
   int n_err = 0;
   int n_strobe = 0;
   int n_dbl = 0;
   int n_big = 0;
   int cyc = 0;
   int last_strobe_cyc = 0;
   logic prev_v = 1'b0;

   pwm_receiver_decoder #(
      .MIN_VALID_US  (900),
      .MAX_VALID_US  (2100),
      .TIMEOUT_US    (TMO),
      .RECOVER_COUNT (3)
   ) u_dut (
      .us_clk      (us_clk),
      .resetn      (resetn),
      .pwm_in      (pwm_in),
      .value_out   (value_out),
      .value_valid (value_valid),
      .signal_lost (signal_lost)
   );

   initial begin
      us_clk = 1'b0;
      forever #500 us_clk = ~us_clk;
   end

   always @(negedge us_clk) begin
      cyc = cyc + 1;
      if (value_valid) begin
         n_strobe = n_strobe + 1;
         last_strobe_cyc = cyc;
      end
      if (value_valid && prev_v) n_dbl = n_dbl + 1;
      if (value_out > 8'd250) n_big = n_big + 1;
      prev_v = value_valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic send_pulse(input int w, input int gap, output logic got, output int lat,
                             output logic [7:0] val);
      got = 1'b0;
      lat = 0;
      val = 8'd0;
      @(negedge us_clk);
      pwm_in = 1'b1;
      repeat (w) @(negedge us_clk);
      pwm_in = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge us_clk);
         if (value_valid && !got) begin
            got = 1'b1;
            lat = i;
            val = value_out;
         end
      end
      repeat (gap) @(negedge us_clk);
   endtask

   task automatic pulse_expect(input string tag, input int w, input logic exp_got, input int exp_val);
      logic       got;
      int         lat;
      logic [7:0] val;
      send_pulse(w, 100, got, lat, val);
      check({tag, "_strobe"}, {31'd0, got}, {31'd0, exp_got});
      if (exp_got) begin
         check({tag, "_latency"}, lat, 4);
         check({tag, "_value"}, {24'd0, val}, exp_val);
      end else begin
         check({tag, "_hold"}, {24'd0, value_out}, exp_val);
      end
   endtask

   initial begin
      int s0;
      int n0;
      logic       got;
      int         lat;
      logic [7:0] val;

      resetn = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(negedge us_clk);
      check("rst_value", {24'd0, value_out}, 0);
      check("rst_valid", {31'd0, value_valid}, 0);
      check("rst_lost", {31'd0, signal_lost}, 1);
      resetn = 1'b1;
      repeat (20) @(negedge us_clk);

      // Recovery from reset: two silent pulses, the third publishes.
      send_pulse(1500, 2500, got, lat, val);
      check("p1_strobe", {31'd0, got}, 0);
      check("p1_lost", {31'd0, signal_lost}, 1);
      send_pulse(1500, 2500, got, lat, val);
      check("p2_strobe", {31'd0, got}, 0);
      pulse_expect("p3", 1500, 1'b1, 125);
      check("p3_lost", {31'd0, signal_lost}, 0);

      pulse_expect("w1004", 1004, 1'b1, 1);
      pulse_expect("w2050", 2050, 1'b1, 250);
      pulse_expect("w950", 950, 1'b1, 0);
      pulse_expect("w1000", 1000, 1'b1, 0);
      pulse_expect("w1999", 1999, 1'b1, 249);
      pulse_expect("w2100", 2100, 1'b1, 250);
      pulse_expect("w2101", 2101, 1'b0, 250);
      pulse_expect("w900", 900, 1'b1, 0);
      pulse_expect("w899", 899, 1'b0, 0);

      pulse_expect("g1500", 1500, 1'b1, 125);
      pulse_expect("w800", 800, 1'b0, 125);
      pulse_expect("g1700", 1700, 1'b1, 175);
      pulse_expect("w2500", 2500, 1'b0, 175);

      // Timeout with the input held low.
      pulse_expect("t1500", 1500, 1'b1, 125);
      s0 = last_strobe_cyc;
      n0 = n_strobe;
      repeat (TMO + 500) @(negedge us_clk);
      check("tmo_strobes", n_strobe - n0, 1);
      check("tmo_delay", last_strobe_cyc - s0, TMO);
      check("tmo_value", {24'd0, value_out}, 0);
      check("tmo_lost", {31'd0, signal_lost}, 1);
      repeat (1500) @(negedge us_clk);
      check("tmo_no_restrobe", n_strobe - n0, 1);

      // A rejected pulse restarts the recovery count.
      pulse_expect("r1", 1500, 1'b0, 0);
      pulse_expect("r2", 1500, 1'b0, 0);
      pulse_expect("r_bad", 800, 1'b0, 0);
      pulse_expect("r3", 1500, 1'b0, 0);
      pulse_expect("r4", 1500, 1'b0, 0);
      pulse_expect("r5", 1700, 1'b1, 175);
      check("r5_lost", {31'd0, signal_lost}, 0);

      // Stuck-high input: failsafe fires mid-measurement, long pulse is rejected.
      n0 = n_strobe;
      @(negedge us_clk);
      pwm_in = 1'b1;
      repeat (TMO + 500) @(negedge us_clk);
      check("stuck_strobes", n_strobe - n0, 1);
      check("stuck_value", {24'd0, value_out}, 0);
      check("stuck_lost", {31'd0, signal_lost}, 1);
      repeat (500) @(negedge us_clk);
      pwm_in = 1'b0;
      repeat (108) @(negedge us_clk);
      check("stuck_release", n_strobe - n0, 1);
      pulse_expect("s1", 1500, 1'b0, 0);
      pulse_expect("s2", 1500, 1'b0, 0);
      pulse_expect("s3", 1500, 1'b1, 125);

      // Reset mid-pulse; the remainder of that pulse must not be measured.
      @(negedge us_clk);
      pwm_in = 1'b1;
      repeat (300) @(negedge us_clk);
      resetn = 1'b0;
      repeat (5) @(negedge us_clk);
      check("midrst_value", {24'd0, value_out}, 0);
      check("midrst_valid", {31'd0, value_valid}, 0);
      check("midrst_lost", {31'd0, signal_lost}, 1);
      resetn = 1'b1;
      repeat (1300) @(negedge us_clk);
      pwm_in = 1'b0;
      repeat (108) @(negedge us_clk);
      pulse_expect("m1", 1500, 1'b0, 0);
      pulse_expect("m2", 1500, 1'b0, 0);
      pulse_expect("m3", 1600, 1'b1, 150);

      check("no_back_to_back", n_dbl, 0);
      check("value_range", n_big, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
